uart_alu_ctrl: RTL and testbench
================================

Name: uart_alu_ctrl

Overview:
- Command sequencer between the UART receiver/transmitter pair and the combinational ALU.
- Collects three received bytes in order (operand A, operand B, opcode), drives the ALU, then starts one UART transmission carrying the result.
- Enforces opcode validity and an inter-byte timeout measured in baud ticks, so a lost byte cannot desynchronise the frame.

Parameters:
- NB_DATA, 8, width of operands, ALU result and UART data bytes.
- NB_OP, 6, opcode width; the low NB_OP bits of the opcode byte are used.
- TIMEOUT_TICKS, 640, i_s_tick count allowed between bytes of one command (about 4 frame times at 16x oversampling); counter width is $clog2(TIMEOUT_TICKS).

Ports:
- i_clock  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_s_tick  in  1  baud-rate oversampling tick (same one the receiver uses)
- i_rx_done_tick  in  1  one-cycle pulse from receiver: byte valid
- i_rx_data  in  NB_DATA  received byte, valid while i_rx_done_tick is high
- i_alu_result  in  NB_DATA  combinational ALU output
- i_tx_done_tick  in  1  one-cycle pulse from transmitter: frame sent
- o_data_a  out  NB_DATA  registered operand A to ALU
- o_data_b  out  NB_DATA  registered operand B to ALU
- o_op  out  NB_OP  registered opcode to ALU
- o_tx_start  out  1  one-cycle pulse: start transmitting o_tx_data
- o_tx_data  out  NB_DATA  registered byte to transmitter
- o_busy  out  1  high in every state except WAIT_A
- o_error  out  1  one-cycle pulse on invalid opcode, timeout or overrun

Behaviour:
- Reset: state WAIT_A; o_data_a, o_data_b, o_op, o_tx_data and the timeout counter all 0; o_tx_start, o_error and o_busy all 0.
- All outputs are registered or Moore-decoded from the state. There is no combinational path from any input to any output.
- WAIT_A:
  - On i_rx_done_tick: latch o_data_a <= i_rx_data, go to WAIT_B, clear the timeout counter.
- WAIT_B:
  - On i_rx_done_tick: latch o_data_b, go to WAIT_OP, clear the counter.
- WAIT_OP:
  - On i_rx_done_tick with a valid opcode: latch o_op <= i_rx_data[NB_OP-1:0], go to CALC.
  - On i_rx_done_tick with an invalid opcode: o_op is unchanged, o_error pulses the next cycle, go to WAIT_A.
- Valid opcodes (localparams): ADD 6'b100000, SUB 6'b100010, AND 6'b100100, OR 6'b100101, XOR 6'b100110, NOR 6'b100111, SRA 6'b000011, SRL 6'b000010.
  - Any other value is invalid.
  - A byte is also invalid if any bit above NB_OP-1 is nonzero.
- Timeout (WAIT_B and WAIT_OP only):
  - Each i_s_tick increments the counter.
  - An i_s_tick arriving when the counter equals TIMEOUT_TICKS-1 sends the FSM to WAIT_A, pulses o_error and clears the counter.
  - If i_rx_done_tick and a timeout-completing tick occur in the same cycle, the byte wins: it is accepted and there is no error.
- CALC: one cycle.
  - o_tx_data <= i_alu_result, sampled one cycle after o_op updates so the ALU has settled.
  - Go to SEND.
- SEND: one cycle; o_tx_start = 1 and o_tx_data is stable. Go to WAIT_TX.
- WAIT_TX: hold until i_tx_done_tick, then go to WAIT_A.
  - o_data_a, o_data_b and o_op hold their values until overwritten by the next command.
- Latency: the opcode's rx_done edge is clock N; CALC is N+1; o_tx_start is high during cycle N+2.
- Overrun: i_rx_done_tick during CALC, SEND or WAIT_TX drops the byte and pulses o_error. State is unchanged; the transmission completes normally.
- i_tx_done_tick outside WAIT_TX is ignored.
- Reset mid-operation returns everything to reset values immediately. A partially received command is discarded.

Decomposition:
- Package uart_alu_pkg:
  - state encoding: 3-bit localparams WAIT_A, WAIT_B, WAIT_OP, CALC, SEND, WAIT_TX;
  - opcode localparams;
  - NB_OP default.
- Sub-module uart_timeout_cnt: tick counter with clear, enable and terminal-count output. Shared later by the TX-side watchdog.
- The opcode-validity check is a function in the package, not a module.

Test Plan:
- Bytes 0x05, 0x03, 0x20 with ALU stub ADD -> o_op=6'b100000, o_tx_start pulses exactly once, 2 cycles after the third rx_done, with o_tx_data=0x08. After i_tx_done_tick, o_busy=0.
- Bytes 0xF0, 0x0F, 0x26 (XOR) -> o_tx_data=0xFF. Then bytes 0x80, 0x01, 0x03 (SRA) -> o_data_a=0x80, o_data_b=0x01, result sent matches the stub.
- Bytes 0x01, 0x02, 0x3F -> o_error pulse, no o_tx_start, FSM in WAIT_A, o_op unchanged. Byte 0x60 (bit 6 set, low bits ADD) -> also rejected.
- Byte 0x01, then 640 i_s_tick with no rx -> o_error on the 640th tick, FSM in WAIT_A. The next 3-byte command executes normally.
- Byte 0x01, then rx_done for 0x02 coincident with the 640th tick -> accepted, FSM in WAIT_OP, no o_error.
- During WAIT_TX inject rx_done 0xAA -> o_error pulse, byte dropped, WAIT_TX persists. Assert i_reset during WAIT_B -> all outputs return to 0 asynchronously.

Source files
------------

// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART/ALU command sequencer: state encoding,
// ALU opcodes and the opcode-validity check.
package uart_alu_pkg;

   localparam int NB_OP_DEFAULT = 6;

   typedef logic [2:0] state_t;

   localparam state_t WAIT_A  = 3'd0;
   localparam state_t WAIT_B  = 3'd1;
   localparam state_t WAIT_OP = 3'd2;
   localparam state_t CALC    = 3'd3;
   localparam state_t SEND    = 3'd4;
   localparam state_t WAIT_TX = 3'd5;

   localparam logic [NB_OP_DEFAULT-1:0] OP_ADD = 6'b100000;
   localparam logic [NB_OP_DEFAULT-1:0] OP_SUB = 6'b100010;
   localparam logic [NB_OP_DEFAULT-1:0] OP_AND = 6'b100100;
   localparam logic [NB_OP_DEFAULT-1:0] OP_OR  = 6'b100101;
   localparam logic [NB_OP_DEFAULT-1:0] OP_XOR = 6'b100110;
   localparam logic [NB_OP_DEFAULT-1:0] OP_NOR = 6'b100111;
   localparam logic [NB_OP_DEFAULT-1:0] OP_SRA = 6'b000011;
   localparam logic [NB_OP_DEFAULT-1:0] OP_SRL = 6'b000010;

   function automatic logic is_valid_op(input logic [NB_OP_DEFAULT-1:0] i_op);
      case (i_op)
         OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
         default:                        return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/uart_timeout_cnt.sv
// Baud-tick counter with synchronous clear and a terminal-count flag that is
// high when an enabled tick lands on the last count.
module uart_timeout_cnt #(
   parameter int TIMEOUT_TICKS = 640
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_terminal
);

   localparam int NB_CNT = $clog2(TIMEOUT_TICKS);
   localparam logic [NB_CNT-1:0] LAST = NB_CNT'(TIMEOUT_TICKS - 1);

   logic [NB_CNT-1:0] r_count;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable) begin
         if (r_count == LAST) r_count <= '0;
         else                 r_count <= r_count + 1'b1;
      end
   end

   assign o_terminal = i_enable && (r_count == LAST);

endmodule

// File: rtl/uart_alu_ctrl.sv
// Sequencer that gathers operand A, operand B and opcode from the UART
// receiver, drives the ALU and sends the result back through the transmitter.
module uart_alu_ctrl
   import uart_alu_pkg::*;
#(
   parameter int NB_DATA       = 8,
   parameter int NB_OP         = NB_OP_DEFAULT,
   parameter int TIMEOUT_TICKS = 640
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_s_tick,
   input  logic               i_rx_done_tick,
   input  logic [NB_DATA-1:0] i_rx_data,
   input  logic [NB_DATA-1:0] i_alu_result,
   input  logic               i_tx_done_tick,
   output logic [NB_DATA-1:0] o_data_a,
   output logic [NB_DATA-1:0] o_data_b,
   output logic [NB_OP-1:0]   o_op,
   output logic               o_tx_start,
   output logic [NB_DATA-1:0] o_tx_data,
   output logic               o_busy,
   output logic               o_error
);

   state_t             r_state;
   state_t             w_next_state;
   logic [NB_DATA-1:0] r_data_a;
   logic [NB_DATA-1:0] r_data_b;
   logic [NB_OP-1:0]   r_op;
   logic [NB_DATA-1:0] r_tx_data;
   logic               r_error;
   logic               w_error_set;
   logic               w_in_timed;
   logic               w_timeout;
   logic               w_op_valid;
   logic               w_tx_start;
   logic               w_busy;

   // Opcode bytes with any bit above the opcode field set are rejected too.
   assign w_op_valid = is_valid_op(i_rx_data[NB_OP-1:0]) &&
                       (i_rx_data[NB_DATA-1:NB_OP] == '0);

   assign w_in_timed = (r_state == WAIT_B) || (r_state == WAIT_OP);

   uart_timeout_cnt #(
      .TIMEOUT_TICKS (TIMEOUT_TICKS)
   ) u_timeout_cnt (
      .i_clock    (i_clock),
      .i_reset    (i_reset),
      .i_clear    (i_rx_done_tick || !w_in_timed),
      .i_enable   (i_s_tick && w_in_timed),
      .o_terminal (w_timeout)
   );

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) r_state <= WAIT_A;
      else         r_state <= w_next_state;
   end

   // A received byte always takes priority over a coincident timeout.
   always_comb begin
      w_next_state = r_state;
      w_error_set  = 1'b0;
      case (r_state)
         WAIT_A: begin
            if (i_rx_done_tick) w_next_state = WAIT_B;
         end
         WAIT_B: begin
            if (i_rx_done_tick) begin
               w_next_state = WAIT_OP;
            end else if (w_timeout) begin
               w_next_state = WAIT_A;
               w_error_set  = 1'b1;
            end
         end
         WAIT_OP: begin
            if (i_rx_done_tick) begin
               w_next_state = w_op_valid ? CALC : WAIT_A;
               w_error_set  = !w_op_valid;
            end else if (w_timeout) begin
               w_next_state = WAIT_A;
               w_error_set  = 1'b1;
            end
         end
         CALC: begin
            w_next_state = SEND;
            w_error_set  = i_rx_done_tick;
         end
         SEND: begin
            w_next_state = WAIT_TX;
            w_error_set  = i_rx_done_tick;
         end
         WAIT_TX: begin
            if (i_tx_done_tick) w_next_state = WAIT_A;
            w_error_set = i_rx_done_tick;
         end
         default: w_next_state = WAIT_A;
      endcase
   end

   always_comb begin
      w_busy     = (r_state != WAIT_A);
      w_tx_start = (r_state == SEND);
   end

   // The result is sampled in CALC, a full cycle after o_op was updated.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_data_a  <= '0;
         r_data_b  <= '0;
         r_op      <= '0;
         r_tx_data <= '0;
         r_error   <= 1'b0;
      end else begin
         if (r_state == WAIT_A && i_rx_done_tick) r_data_a <= i_rx_data;
         if (r_state == WAIT_B && i_rx_done_tick) r_data_b <= i_rx_data;
         if (r_state == WAIT_OP && i_rx_done_tick && w_op_valid)
            r_op <= i_rx_data[NB_OP-1:0];
         if (r_state == CALC) r_tx_data <= i_alu_result;
         r_error <= w_error_set;
      end
   end

   assign o_data_a   = r_data_a;
   assign o_data_b   = r_data_b;
   assign o_op       = r_op;
   assign o_tx_data  = r_tx_data;
   assign o_tx_start = w_tx_start;
   assign o_busy     = w_busy;
   assign o_error    = r_error;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Self-checking bench for uart_alu_ctrl with a behavioural ALU stub and a
// scoreboard of expected transmitted bytes.
module tb_uart_alu_ctrl;

   logic       i_clock = 1'b0;
   logic       i_reset;
   logic       i_s_tick;
   logic       i_rx_done_tick;
   logic [7:0] i_rx_data;
   logic [7:0] i_alu_result;
   logic       i_tx_done_tick;
   logic [7:0] o_data_a;
   logic [7:0] o_data_b;
   logic [5:0] o_op;
   logic       o_tx_start;
   logic [7:0] o_tx_data;
   logic       o_busy;
   logic       o_error;

   int         checks   = 0;
   int         failures = 0;
   logic [7:0] sb_q[$];
   logic [5:0] last_op;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] op;
      logic       err;
      logic [7:0] res;
   } vec_t;

   vec_t vecs[11];

   uart_alu_ctrl dut (
      .i_clock        (i_clock),
      .i_reset        (i_reset),
      .i_s_tick       (i_s_tick),
      .i_rx_done_tick (i_rx_done_tick),
      .i_rx_data      (i_rx_data),
      .i_alu_result   (i_alu_result),
      .i_tx_done_tick (i_tx_done_tick),
      .o_data_a       (o_data_a),
      .o_data_b       (o_data_b),
      .o_op           (o_op),
      .o_tx_start     (o_tx_start),
      .o_tx_data      (o_tx_data),
      .o_busy         (o_busy),
      .o_error        (o_error)
   );

   always #5 i_clock = ~i_clock;

   always_comb begin
      i_alu_result = 8'h00;
      case (o_op)
         6'b100000: i_alu_result = o_data_a + o_data_b;
         6'b100010: i_alu_result = o_data_a - o_data_b;
         6'b100100: i_alu_result = o_data_a & o_data_b;
         6'b100101: i_alu_result = o_data_a | o_data_b;
         6'b100110: i_alu_result = o_data_a ^ o_data_b;
         6'b100111: i_alu_result = ~(o_data_a | o_data_b);
         6'b000011: i_alu_result = 8'($signed(o_data_a) >>> o_data_b);
         6'b000010: i_alu_result = o_data_a >> o_data_b;
         default:   i_alu_result = 8'h00;
      endcase
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Every transmit start must match the oldest expected result.
   always @(negedge i_clock) begin
      if (o_tx_start === 1'b1) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_tx actual=%0h required=no_transmission", o_tx_data);
         end else begin
            chk("tx_data", {56'd0, o_tx_data}, {56'd0, sb_q.pop_front()});
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic cycle();
      @(negedge i_clock);
   endtask

   task automatic idle(input int n);
      repeat (n) cycle();
   endtask

   task automatic send_byte(input logic [7:0] b);
      i_rx_data      = b;
      i_rx_done_tick = 1'b1;
      cycle();
      i_rx_done_tick = 1'b0;
   endtask

   task automatic finish_tx();
      idle(3);
      i_tx_done_tick = 1'b1;
      cycle();
      i_tx_done_tick = 1'b0;
      chk("busy_after_tx", {63'd0, o_busy}, 64'd0);
   endtask

   task automatic run_cmd(input vec_t v);
      send_byte(v.a);
      idle(1);
      send_byte(v.b);
      idle(1);
      if (!v.err) sb_q.push_back(v.res);
      send_byte(v.op);
      if (v.err) begin
         chk("bad_op_error", {63'd0, o_error}, 64'd1);
         chk("bad_op_idle", {63'd0, o_busy}, 64'd0);
         chk("bad_op_keep", {58'd0, o_op}, {58'd0, last_op});
         cycle();
         chk("bad_op_error_clr", {63'd0, o_error}, 64'd0);
         idle(3);
      end else begin
         chk("calc_no_start", {63'd0, o_tx_start}, 64'd0);
         chk("op_latched", {58'd0, o_op}, {58'd0, v.op[5:0]});
         chk("operands", {48'd0, o_data_a, o_data_b}, {48'd0, v.a, v.b});
         cycle();
         chk("send_start", {63'd0, o_tx_start}, 64'd1);
         cycle();
         chk("start_single", {63'd0, o_tx_start}, 64'd0);
         chk("busy_wait_tx", {63'd0, o_busy}, 64'd1);
         finish_tx();
         last_op = v.op[5:0];
      end
   endtask

   initial begin
      int early;
      vecs[0]  = '{8'h05, 8'h03, 8'h20, 1'b0, 8'h08};
      vecs[1]  = '{8'hF0, 8'h0F, 8'h26, 1'b0, 8'hFF};
      vecs[2]  = '{8'h80, 8'h01, 8'h03, 1'b0, 8'hC0};
      vecs[3]  = '{8'h01, 8'h02, 8'h3F, 1'b1, 8'h00};
      vecs[4]  = '{8'h01, 8'h02, 8'h60, 1'b1, 8'h00};
      vecs[5]  = '{8'h0A, 8'h03, 8'h22, 1'b0, 8'h07};
      vecs[6]  = '{8'h0C, 8'h0A, 8'h24, 1'b0, 8'h08};
      vecs[7]  = '{8'h0C, 8'h0A, 8'h25, 1'b0, 8'h0E};
      vecs[8]  = '{8'h0C, 8'h0A, 8'h27, 1'b0, 8'hF1};
      vecs[9]  = '{8'h80, 8'h03, 8'h02, 1'b0, 8'h10};
      vecs[10] = '{8'h12, 8'h34, 8'h00, 1'b1, 8'h00};

      i_reset        = 1'b1;
      i_s_tick       = 1'b0;
      i_rx_done_tick = 1'b0;
      i_rx_data      = 8'h00;
      i_tx_done_tick = 1'b0;
      last_op        = 6'd0;
      idle(2);
      chk("reset_outputs", {31'd0, o_data_a, o_data_b, o_op, o_tx_data, o_tx_start, o_error, o_busy}, 64'd0);
      i_reset = 1'b0;
      idle(2);

      for (int i = 0; i < 11; i++) run_cmd(vecs[i]);

      // Timeout after operand A: error exactly on the 640th tick.
      send_byte(8'h01);
      i_s_tick = 1'b1;
      early = 0;
      for (int i = 1; i <= 640; i++) begin
         cycle();
         if (i < 640) begin
            if (o_error === 1'b1) early++;
         end else begin
            chk("timeout_error", {63'd0, o_error}, 64'd1);
            chk("timeout_idle", {63'd0, o_busy}, 64'd0);
         end
      end
      i_s_tick = 1'b0;
      chk("timeout_early_errors", early, 0);
      idle(2);
      run_cmd(vecs[0]);

      // Byte arriving on the same cycle as the timeout-completing tick wins.
      send_byte(8'h01);
      i_s_tick = 1'b1;
      idle(639);
      send_byte(8'h02);
      i_s_tick = 1'b0;
      chk("coincident_no_error", {63'd0, o_error}, 64'd0);
      chk("coincident_busy", {63'd0, o_busy}, 64'd1);
      chk("coincident_b", {56'd0, o_data_b}, 64'h02);
      idle(1);
      sb_q.push_back(8'h03);
      send_byte(8'h20);
      cycle();
      chk("coincident_start", {63'd0, o_tx_start}, 64'd1);
      finish_tx();

      // Overrun while waiting for the transmitter.
      send_byte(8'h10);
      idle(1);
      send_byte(8'h01);
      idle(1);
      sb_q.push_back(8'h0F);
      send_byte(8'h22);
      idle(2);
      send_byte(8'hAA);
      chk("overrun_error", {63'd0, o_error}, 64'd1);
      chk("overrun_busy", {63'd0, o_busy}, 64'd1);
      chk("overrun_dropped", {48'd0, o_data_a, o_data_b}, 64'h1001);
      finish_tx();
      run_cmd('{8'hCC, 8'hAA, 8'h24, 1'b0, 8'h88});

      // Asynchronous reset while waiting for operand B.
      send_byte(8'h77);
      idle(1);
      #2 i_reset = 1'b1;
      #1 chk("async_reset", {31'd0, o_data_a, o_data_b, o_op, o_tx_data, o_tx_start, o_error, o_busy}, 64'd0);
      cycle();
      i_reset = 1'b0;
      last_op = 6'd0;
      cycle();
      run_cmd('{8'h02, 8'h03, 8'h20, 1'b0, 8'h05});

      idle(2);
      chk("scoreboard_empty", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
